// File: rtl/wd_supervisor.sv
`default_nettype none
// ============================================================================
// Module      : wd_supervisor
// Description : Watchdog supervisor. Counts watchdog timeout ticks as missed
//               service windows, accepts a two-word key sequence as a kick,
//               and after LIMIT consecutive misses issues a timed system
//               reset pulse followed by a hold-off period. Exposed as a
//               16-bit memory-mapped slave.
//               Optional build macro WD_SUPERVISOR_LOCK_EN: once armed, the
//               arm bit can no longer be cleared (and LIMIT stays frozen)
//               until reset.
// Revision    : 1.0 - initial release
// ============================================================================
module wd_supervisor #(
    parameter int RST_PULSE_CYCLES = 16,
    parameter int HOLDOFF_CYCLES   = 256,
    parameter int DEFAULT_LIMIT    = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    input  logic        timeout_tick,
    output logic        irq,
    output logic        wd_reset_out
);

    // FSM encoding; the value is visible in STATUS[6:4]
    localparam logic [2:0] c_ST_DISARMED = 3'd0;
    localparam logic [2:0] c_ST_ARMED    = 3'd1;
    localparam logic [2:0] c_ST_PULSE    = 3'd2;
    localparam logic [2:0] c_ST_HOLDOFF  = 3'd3;

    // Register map
    localparam logic [2:0] c_ADDR_STATUS  = 3'd0;
    localparam logic [2:0] c_ADDR_CONTROL = 3'd1;
    localparam logic [2:0] c_ADDR_KICK    = 3'd2;
    localparam logic [2:0] c_ADDR_LIMIT   = 3'd3;
    localparam logic [2:0] c_ADDR_MISS    = 3'd4;

    localparam logic [15:0] c_KEY_FIRST  = 16'h5A5A;
    localparam logic [15:0] c_KEY_SECOND = 16'hA5A5;

    // One shared down-counter times both the pulse and the hold-off
    localparam int c_CNT_MAX = (RST_PULSE_CYCLES > HOLDOFF_CYCLES) ?
                               RST_PULSE_CYCLES : HOLDOFF_CYCLES;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX) + 1;

    localparam logic [c_CNT_W-1:0] c_PULSE_LOAD = c_CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_HOLD_LOAD  = c_CNT_W'(HOLDOFF_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE    = c_CNT_W'(1);
    localparam logic [3:0]         c_DEF_LIMIT  = 4'(DEFAULT_LIMIT);

    // Registered state
    logic [2:0]         r_state;
    logic [3:0]         r_miss_cnt;
    logic [3:0]         r_limit;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_arm;
    logic               r_irq_en;
    logic               r_warn;
    logic               r_expired;
    logic               r_key_armed;
    logic               r_wd_reset_out;
    logic [15:0]        r_readdata;

    // Combinational decode
    logic       w_write;
    logic       w_wr_status;
    logic       w_wr_control;
    logic       w_wr_kick;
    logic       w_wr_limit;
    logic       w_arm_next;
    logic       w_kick;
    logic       w_miss_event;
    logic       w_limit_hit;
    logic [3:0] w_miss_inc;
    logic [3:0] w_limit_wdata;

    assign w_write      = chipselect & ~write_n;
    assign w_wr_status  = w_write && (address == c_ADDR_STATUS);
    assign w_wr_control = w_write && (address == c_ADDR_CONTROL);
    assign w_wr_kick    = w_write && (address == c_ADDR_KICK);
    assign w_wr_limit   = w_write && (address == c_ADDR_LIMIT);

    // A kick completes only on the second key word with the first one pending
    assign w_kick = w_wr_kick && (writedata == c_KEY_SECOND) && r_key_armed;

    // A stored limit of 0 would never be reachable, so 0 is promoted to 1
    assign w_limit_wdata = (writedata[3:0] == 4'd0) ? 4'd1 : writedata[3:0];

    assign w_miss_inc = r_miss_cnt + 4'd1;

    // Next value of the arm bit, including this cycle's CONTROL write
    always_comb begin
        w_arm_next = r_arm;
        if (w_wr_control) begin
`ifdef WD_SUPERVISOR_LOCK_EN
            // Sticky once set: a later write of 0 cannot disarm
            w_arm_next = r_arm | writedata[0];
`else
            w_arm_next = writedata[0];
`endif
        end
    end

    // A miss counts only while armed and staying armed; a kick in the
    // same cycle overrides the tick, and the count saturates at LIMIT
    always_comb begin
        w_miss_event = (r_state == c_ST_ARMED) && w_arm_next && timeout_tick &&
                       !w_kick && (r_miss_cnt < r_limit);
        w_limit_hit  = w_miss_event && (w_miss_inc == r_limit);
    end

    // Bus-writable configuration and key tracking
    always_ff @(posedge clk) begin
        if (reset) begin
            r_arm       <= 1'b0;
            r_irq_en    <= 1'b0;
            r_limit     <= c_DEF_LIMIT;
            r_key_armed <= 1'b0;
        end else begin
            r_arm <= w_arm_next;
            if (w_wr_control) begin
                r_irq_en <= writedata[1];
            end
            // LIMIT only changes while disarmed; under the lock option the
            // supervisor never returns to DISARMED after first arming
            if (w_wr_limit && (r_state == c_ST_DISARMED)) begin
                r_limit <= w_limit_wdata;
            end
            if (r_state == c_ST_PULSE) begin
                r_key_armed <= 1'b0;
            end else if (w_wr_kick) begin
                r_key_armed <= (writedata == c_KEY_FIRST);
            end
        end
    end

    // Sticky status flags; a set event beats a same-cycle clear
    always_ff @(posedge clk) begin
        if (reset) begin
            r_warn    <= 1'b0;
            r_expired <= 1'b0;
        end else begin
            r_warn    <= w_miss_event | (r_warn & ~(w_wr_status & writedata[0]));
            r_expired <= w_limit_hit  | (r_expired & ~(w_wr_status & writedata[1]));
        end
    end

    // Supervisor FSM with miss counter, pulse/hold-off timer and reset output
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= c_ST_DISARMED;
            r_miss_cnt     <= 4'd0;
            r_cnt          <= '0;
            r_wd_reset_out <= 1'b0;
        end else begin
            case (r_state)
                c_ST_DISARMED: begin
                    r_miss_cnt <= 4'd0;
                    if (w_arm_next) begin
                        r_state <= c_ST_ARMED;
                    end
                end
                c_ST_ARMED: begin
                    if (!w_arm_next) begin
                        r_state    <= c_ST_DISARMED;
                        r_miss_cnt <= 4'd0;
                    end else if (w_kick) begin
                        r_miss_cnt <= 4'd0;
                    end else if (w_miss_event) begin
                        r_miss_cnt <= w_miss_inc;
                        if (w_limit_hit) begin
                            r_state        <= c_ST_PULSE;
                            r_cnt          <= c_PULSE_LOAD;
                            r_wd_reset_out <= 1'b1;
                        end
                    end
                end
                c_ST_PULSE: begin
                    if (r_cnt == '0) begin
                        r_state        <= c_ST_HOLDOFF;
                        r_cnt          <= c_HOLD_LOAD;
                        r_wd_reset_out <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - c_CNT_ONE;
                    end
                end
                c_ST_HOLDOFF: begin
                    if (r_cnt == '0) begin
                        r_miss_cnt <= 4'd0;
                        // A disarm written during the sequence takes effect here
                        r_state    <= r_arm ? c_ST_ARMED : c_ST_DISARMED;
                    end else begin
                        r_cnt <= r_cnt - c_CNT_ONE;
                    end
                end
                default: begin
                    r_state        <= c_ST_DISARMED;
                    r_miss_cnt     <= 4'd0;
                    r_wd_reset_out <= 1'b0;
                end
            endcase
        end
    end

    // Read mux, registered every cycle for a fixed 1-cycle read latency
    always_ff @(posedge clk) begin
        if (reset) begin
            r_readdata <= 16'h0000;
        end else begin
            case (address)
                c_ADDR_STATUS:  r_readdata <= {9'b0, r_state, 2'b0, r_expired, r_warn};
                c_ADDR_CONTROL: r_readdata <= {14'b0, r_irq_en, r_arm};
                c_ADDR_LIMIT:   r_readdata <= {12'b0, r_limit};
                c_ADDR_MISS:    r_readdata <= {12'b0, r_miss_cnt};
                default:        r_readdata <= 16'h0000;
            endcase
        end
    end

    assign readdata     = r_readdata;
    assign irq          = r_warn & r_irq_en;
    assign wd_reset_out = r_wd_reset_out;

endmodule
`default_nettype wire

// File: tb/tb_wd_supervisor.sv
`default_nettype none
// ============================================================================
// Module      : tb_wd_supervisor
// Description : Self-checking bench for wd_supervisor. Stimulus tasks push
//               hand-computed expectations into a scoreboard queue; a monitor
//               pops and compares them just after each rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wd_supervisor;

`ifdef WD_SUPERVISOR_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    // Which DUT output a scoreboard entry refers to
    localparam int K_RDATA = 0;
    localparam int K_WDRST = 1;
    localparam int K_IRQ   = 2;

    typedef struct {
        int          kind;
        string       name;
        logic [15:0] exp;
    } chk_t;

    logic        clk;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic        timeout_tick;
    logic        irq;
    logic        wd_reset_out;

    chk_t sb[$];
    int   total;
    int   bad;

    wd_supervisor dut (
        .clk          (clk),
        .reset        (reset),
        .address      (address),
        .chipselect   (chipselect),
        .write_n      (write_n),
        .writedata    (writedata),
        .readdata     (readdata),
        .timeout_tick (timeout_tick),
        .irq          (irq),
        .wd_reset_out (wd_reset_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: everything queued during a cycle is due just after the next edge
    always @(posedge clk) begin
        #1;
        while (sb.size() > 0) begin
            chk_t        e;
            logic [15:0] act;
            e = sb.pop_front();
            case (e.kind)
                K_WDRST: act = {15'b0, wd_reset_out};
                K_IRQ:   act = {15'b0, irq};
                default: act = readdata;
            endcase
            total++;
            if (act !== e.exp) begin
                bad++;
                $display("FAIL %s: got %h expected %h (t=%0t)", e.name, act, e.exp, $time);
            end
        end
    end

    task automatic push(input int k, input string n, input logic [15:0] e);
        chk_t c;
        c.kind = k;
        c.name = n;
        c.exp  = e;
        sb.push_back(c);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    // Write with a timeout tick in the same cycle
    task automatic wr_tick(input logic [2:0] a, input logic [15:0] d);
        timeout_tick = 1'b1;
        wr(a, d);
        timeout_tick = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, input logic [15:0] e, input string n);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        push(K_RDATA, n, e);
        @(negedge clk);
        chipselect = 1'b0;
    endtask

    task automatic pin(input int k, input logic [15:0] e, input string n);
        push(k, n, e);
        @(negedge clk);
    endtask

    task automatic tick();
        timeout_tick = 1'b1;
        @(negedge clk);
        timeout_tick = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        total        = 0;
        bad          = 0;
        reset        = 1'b1;
        address      = 3'd0;
        chipselect   = 1'b0;
        write_n      = 1'b1;
        writedata    = 16'h0000;
        timeout_tick = 1'b0;
        cyc(3);

        // Reset state
        push(K_RDATA, "reset_readdata", 16'h0000);
        push(K_WDRST, "reset_wdrst", 16'h0000);
        push(K_IRQ, "reset_irq", 16'h0000);
        @(negedge clk);
        total++;
        if (readdata !== 16'h0000) begin
            bad++;
            $display("FAIL direct_reset_readdata: got %h (t=%0t)", readdata, $time);
        end
        total++;
        if (wd_reset_out !== 1'b0) begin
            bad++;
            $display("FAIL direct_reset_wdrst: got %b (t=%0t)", wd_reset_out, $time);
        end
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("FAIL direct_reset_irq: got %b (t=%0t)", irq, $time);
        end
        reset = 1'b0;
        rd(3'd0, 16'h0000, "reset_status");
        rd(3'd4, 16'h0000, "reset_miss");
        rd(3'd1, 16'h0000, "reset_control");
        rd(3'd3, 16'h0003, "reset_limit");

        // LIMIT 0 becomes 1; ticks ignored while disarmed
        wr(3'd3, 16'h0000);
        rd(3'd3, 16'h0001, "limit_zero_to_one");
        tick();
        rd(3'd4, 16'h0000, "disarmed_tick_ignored");

        // LIMIT=2, arm with irq enabled
        wr(3'd3, 16'h0002);
        rd(3'd3, 16'h0002, "limit_two");
        wr(3'd1, 16'h0003);
        cyc(2);
        rd(3'd1, 16'h0003, "control_armed");
        rd(3'd0, 16'h0010, "status_armed");
        wr(3'd3, 16'h0005);
        rd(3'd3, 16'h0002, "limit_locked_when_armed");

        // First miss
        tick();
        rd(3'd4, 16'h0001, "miss_one");
        rd(3'd0, 16'h0011, "status_warn");
        pin(K_IRQ, 16'h0001, "irq_on_warn");
        wr(3'd0, 16'h0001);
        rd(3'd0, 16'h0010, "warn_cleared");
        pin(K_IRQ, 16'h0000, "irq_after_clear");

        // Valid kick
        wr(3'd2, 16'h5A5A);
        wr(3'd2, 16'hA5A5);
        rd(3'd4, 16'h0000, "kick_clears_miss");

        // Broken key sequence: no kick, tick still counts
        wr(3'd2, 16'h5A5A);
        wr(3'd2, 16'h1234);
        wr(3'd2, 16'hA5A5);
        tick();
        rd(3'd4, 16'h0001, "broken_key_miss");
        rd(3'd0, 16'h0011, "broken_key_warn");
        wr(3'd0, 16'h0001);

        // Writes to other addresses keep the pending key
        wr(3'd2, 16'h5A5A);
        wr(3'd1, 16'h0003);
        wr(3'd2, 16'hA5A5);
        rd(3'd4, 16'h0000, "key_survives_other_write");

        // Kick and tick in the same cycle: kick wins
        wr(3'd2, 16'h5A5A);
        wr_tick(3'd2, 16'hA5A5);
        rd(3'd4, 16'h0000, "kick_tick_miss");
        rd(3'd0, 16'h0010, "kick_tick_nowarn");

        // Expiry: one miss, then the limit-reaching tick
        tick();
        pin(K_WDRST, 16'h0000, "wdrst_before_expiry");
        for (int k = 0; k <= 16; k++) begin
            if (k == 0) timeout_tick = 1'b1;
            if (k == 4) begin
                address    = 3'd0;
                chipselect = 1'b1;
                write_n    = 1'b1;
                push(K_RDATA, "status_pulse", 16'h0023);
            end
            if (k == 6) begin
                address    = 3'd4;
                chipselect = 1'b1;
                write_n    = 1'b1;
                push(K_RDATA, "miss_at_limit", 16'h0002);
            end
            if (k == 8) push(K_IRQ, "irq_during_pulse", 16'h0001);
            push(K_WDRST, (k < 16) ? "wdrst_pulse_high" : "wdrst_pulse_end",
                 (k < 16) ? 16'h0001 : 16'h0000);
            @(negedge clk);
            timeout_tick = 1'b0;
            chipselect   = 1'b0;
        end

        // Hold-off: clear flags, request disarm
        rd(3'd0, 16'h0033, "status_holdoff");
        wr(3'd0, 16'h0003);
        rd(3'd0, 16'h0030, "flags_cleared_holdoff");
        wr(3'd1, 16'h0002);
        rd(3'd1, LOCK ? 16'h0003 : 16'h0002, "control_disarm_holdoff");
        tick();
        cyc(270);
        rd(3'd0, LOCK ? 16'h0010 : 16'h0000, "status_after_holdoff");
        rd(3'd4, 16'h0000, "miss_after_holdoff");

        // Re-arm without irq, expire again, then reset during the pulse
        wr(3'd1, 16'h0001);
        cyc(2);
        tick();
        pin(K_IRQ, 16'h0000, "irq_masked");
        tick();
        cyc(3);
        pin(K_WDRST, 16'h0001, "wdrst_second_pulse");
        reset = 1'b1;
        push(K_WDRST, "wdrst_dropped_by_reset", 16'h0000);
        @(negedge clk);
        total++;
        if (wd_reset_out !== 1'b0) begin
            bad++;
            $display("FAIL direct_wdrst_after_reset: got %b (t=%0t)", wd_reset_out, $time);
        end
        reset = 1'b0;
        rd(3'd0, 16'h0000, "status_after_reset");
        rd(3'd1, 16'h0000, "control_after_reset");
        rd(3'd3, 16'h0003, "limit_after_reset");

        // Disarm attempt from ARMED
        wr(3'd1, 16'h0001);
        cyc(2);
        wr(3'd1, 16'h0000);
        cyc(2);
        rd(3'd0, LOCK ? 16'h0010 : 16'h0000, "status_disarm_attempt");
        rd(3'd1, LOCK ? 16'h0001 : 16'h0000, "control_disarm_attempt");

        cyc(2);
        if (total < 12) begin
            bad++;
            $display("FAIL too_few_checks: total=%0d", total);
        end
        if (bad == 0) begin
            $display("PASS");
        end else begin
            $display("FAIL bad=%0d", bad);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wd_supervisor.md
# wd_supervisor

- Sequences the watchdog reset timer: counts its timeout ticks as missed service windows and requires a two-word key write to service it.
- After a programmable number of consecutive misses it drives a timed system-reset pulse, then a hold-off.
- Sits between the watchdog timer's timeout output and the board reset logic, as a 16-bit memory-mapped slave on the CPU bus.

## Interface
Parameters:
- RST_PULSE_CYCLES, 16, cycles `wd_reset_out` is held high (≥1)
- HOLDOFF_CYCLES, 256, cycles after the pulse before misses are counted again (≥1)
- DEFAULT_LIMIT, 3, miss limit after reset (1..15)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- address  in  3  register select
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  16  write data
- readdata  out  16  registered read data
- timeout_tick  in  1  one-cycle pulse per expired timer period
- irq  out  1  warn_flag AND irq_en
- wd_reset_out  out  1  active-high system reset request

## Operation
A write is chipselect && !write_n. Register map:
- 0 STATUS
  - Read: {9'b0, state[2:0], 2'b0, expired, warn_flag}.
  - Write with bit0=1 clears warn_flag; write with bit1=1 clears expired.
- 1 CONTROL
  - Bit0 arm, bit1 irq_en; reads return {14'b0, irq_en, arm}.
- 2 KICK
  - Write 16'h5A5A sets key_armed.
  - A following KICK write of 16'hA5A5 while key_armed completes a kick.
  - Any other KICK value clears key_armed.
  - Writes to other addresses do not affect key_armed.
  - Reads return 0.
- 3 LIMIT
  - Bits[3:0]; a written value of 0 stores 1.
  - Writable only in DISARMED; ignored otherwise.
- 4 MISS
  - Read-only; {12'b0, miss_cnt[3:0]}.
- 5–7: read 0, writes ignored.

FSM, encoded in state[2:0]:
- DISARMED (0)
  - Ticks and kicks are ignored; miss_cnt=0.
  - Goes to ARMED the cycle after arm is written 1.
- ARMED (1)
  - A completed kick clears miss_cnt.
  - A tick with no kick in the same cycle increments miss_cnt and sets warn_flag.
  - When the increment makes miss_cnt equal LIMIT: go to PULSE, set expired.
  - Writing arm=0 returns to DISARMED and clears miss_cnt.
- PULSE (2)
  - wd_reset_out=1 for exactly RST_PULSE_CYCLES cycles, then HOLDOFF.
  - Ticks and kicks are ignored; key_armed is cleared.
- HOLDOFF (3)
  - Lasts HOLDOFF_CYCLES cycles, then ARMED with miss_cnt=0.
  - Ticks and kicks are ignored.
- arm=0 written during PULSE/HOLDOFF is stored, and the sequence completes first. On leaving HOLDOFF, go to DISARMED if arm=0.

Boundary rules:
- A kick completing and a tick in the same cycle: the kick wins; miss_cnt=0 and warn_flag is not set.
- miss_cnt saturates at LIMIT; it never wraps.
- warn_flag or expired set and a clear write in the same cycle: set wins.
- The pulse/hold-off counter width is clog2(max(RST_PULSE_CYCLES, HOLDOFF_CYCLES)) + 1.

## Timing
- Reset values:
  - readdata=0, irq=0, wd_reset_out=0.
  - state=DISARMED, miss_cnt=0, LIMIT=DEFAULT_LIMIT.
  - arm=0, irq_en=0, warn_flag=0, expired=0, key_armed=0.
- readdata is updated every cycle from the address mux, giving 1-cycle read latency.
- Register writes take effect on the edge of the write cycle.
- Status reflects the change on the next read.
- wd_reset_out rises on the clock edge after the limit-reaching tick is sampled.
- wd_reset_out falls RST_PULSE_CYCLES cycles later.
- irq is combinational from registered warn_flag/irq_en.
- Reset asserted mid-PULSE drops wd_reset_out on the next edge.

## Configuration
WD_SUPERVISOR_LOCK_EN:
- Defined:
  - Once arm=1, writes of arm=0 are ignored until reset.
  - LIMIT is frozen from first arming.
- Undefined: arm is freely writable, as described above.

## Test plan
- Reset → readdata=0, wd_reset_out=0, irq=0; STATUS read = 16'h0000; MISS = 0.
- LIMIT=2, arm=1, irq_en=1, one tick → MISS=1, warn_flag=1, irq=1; second tick → wd_reset_out high exactly 16 cycles from the next edge, STATUS state=2 then 3, expired=1.
- Armed, KICK 5A5A then A5A5 → MISS=0. KICK 5A5A, 1234, A5A5 → no kick, and a tick still increments MISS.
- Kick completion and tick in the same cycle → MISS stays 0, warn_flag stays 0.
- LIMIT write of 0 while disarmed → reads 1. LIMIT write of 5 while armed → unchanged.
- Reset asserted during PULSE → wd_reset_out=0 on the next edge, state=0.
- With WD_SUPERVISOR_LOCK_EN: arm then write CONTROL=0 → state remains ARMED.
